// File: rtl/vec_csr_unit.sv
// vec_csr_unit: vector vtype/vl/vstart and fixed-point CSR unit.
// Config requests (vset*) are latched in IDLE, wait in DRAIN until no vector
// ops are in flight, then commit in COMMIT with a one-cycle cfg_done pulse.
// Ports:
//   cfg_*    - vset* request/response (avl, vtype, rs1/rd x0 flags, done, vl)
//   issue_*, retire_valid - in-flight vector op tracking
//   csr_*    - CSR access, combinational read data and illegal flag
//   vstart_clr, vxsat_set - datapath side effects
//   sew, vlmul, vlmax, vl, vstart, vta, vma, vill, vxrm, vxsat - current state
//
// state  | meaning
// IDLE   | accepts config requests and CSR accesses, allows issue
// DRAIN  | request latched, waiting for in-flight count to reach zero
// COMMIT | apply new vtype/vl, clear vstart, pulse cfg_done
module vec_csr_unit #(
  parameter int XLEN         = 32,
  parameter int VLEN         = 512,
  parameter int ELEN         = 64,
  parameter int MAX_INFLIGHT = 4
) (
  input  logic                     clk,
  input  logic                     n_rst,
  input  logic                     cfg_valid,
  output logic                     cfg_ready,
  input  logic [XLEN-1:0]          cfg_avl,
  input  logic [XLEN-1:0]          cfg_vtype,
  input  logic                     cfg_rs1_zero,
  input  logic                     cfg_rd_zero,
  output logic                     cfg_done,
  output logic [XLEN-1:0]          cfg_vl,
  input  logic                     issue_valid,
  output logic                     issue_ready,
  input  logic                     retire_valid,
  input  logic                     csr_valid,
  output logic                     csr_ready,
  input  logic [1:0]               csr_op,
  input  logic                     csr_wr_intent,
  input  logic [11:0]              csr_addr,
  input  logic [XLEN-1:0]          csr_wdata,
  output logic [XLEN-1:0]          csr_rdata,
  output logic                     csr_illegal,
  input  logic                     vstart_clr,
  input  logic                     vxsat_set,
  output logic [6:0]               sew,
  output logic [2:0]               vlmul,
  output logic [$clog2(VLEN):0]    vlmax,
  output logic [XLEN-1:0]          vl,
  output logic [$clog2(VLEN)-1:0]  vstart,
  output logic                     vta,
  output logic                     vma,
  output logic                     vill,
  output logic [1:0]               vxrm,
  output logic                     vxsat
);

  localparam int VLW = $clog2(VLEN);
  localparam int CW  = $clog2(MAX_INFLIGHT + 1);

  typedef enum logic [1:0] {IDLE, DRAIN, COMMIT} state_t;

  state_t           state_q;
  logic [XLEN-1:0]  req_avl_q;
  logic [XLEN-2:0]  req_vtype_q;
  logic             req_rs1z_q, req_rdz_q;
  logic             vill_q, vma_q, vta_q;
  logic [2:0]       vsew_q, vlmul_q;
  logic [XLEN-1:0]  vl_q;
  logic [VLW-1:0]   vstart_q, vstart_d;
  logic [1:0]       vxrm_q, vxrm_d;
  logic             vxsat_q, vxsat_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             cfg_done_q;
  logic [XLEN-1:0]  cfg_vl_q;

  // VLMAX = VLEN/SEW scaled by LMUL; fractional LMUL is a right shift by 8-vlmul.
  function automatic logic [VLW:0] calc_vlmax(input logic [2:0] vsew_f, input logic [2:0] vlmul_f);
    logic [VLW:0] base;
    base = (VLW+1)'(VLEN / 8) >> vsew_f;
    if (vlmul_f[2]) return base >> (4'd8 - {1'b0, vlmul_f});
    else            return base << vlmul_f[1:0];
  endfunction

  logic [2:0]      req_vsew, req_vlmul;
  logic [15:0]     sew_scaled, elen_scaled;
  logic            req_bad, new_vill;
  logic [VLW:0]    vlmax_cur, new_vlmax;
  logic [XLEN-1:0] new_vlmax_x, avl_sel, new_vl;

  assign req_vsew  = req_vtype_q[5:3];
  assign req_vlmul = req_vtype_q[2:0];

  // SEW > ELEN*LMUL, cross-multiplied so fractional LMUL stays integral.
  always_comb begin
    sew_scaled  = 16'd8 << req_vsew;
    elen_scaled = 16'(ELEN);
    if (req_vlmul[2]) sew_scaled  = sew_scaled << (4'd8 - {1'b0, req_vlmul});
    else              elen_scaled = elen_scaled << req_vlmul[1:0];
  end

  assign req_bad     = (req_vsew > 3'd3) | (req_vlmul == 3'd4) |
                       (|req_vtype_q[XLEN-2:8]) | (sew_scaled > elen_scaled);
  assign vlmax_cur   = calc_vlmax(vsew_q, vlmul_q);
  assign new_vlmax   = calc_vlmax(req_vsew, req_vlmul);
  assign new_vlmax_x = {{(XLEN-VLW-1){1'b0}}, new_vlmax};
  // Keeping vl across a VLMAX change is not allowed; flag vill instead.
  assign new_vill    = req_bad | (req_rs1z_q & req_rdz_q & (new_vlmax != vlmax_cur));

  always_comb begin
    if (!req_rs1z_q)     avl_sel = req_avl_q;
    else if (!req_rdz_q) avl_sel = new_vlmax_x;
    else                 avl_sel = vl_q;
  end

  assign new_vl = new_vill ? '0 : ((avl_sel > new_vlmax_x) ? new_vlmax_x : avl_sel);

  logic            csr_unmapped, csr_ro, csr_we;
  logic [XLEN-1:0] csr_new;

  always_comb begin
    csr_rdata    = '0;
    csr_unmapped = 1'b0;
    csr_ro       = 1'b0;
    case (csr_addr)
      12'h008: csr_rdata[VLW-1:0] = vstart_q;
      12'h009: csr_rdata[0]       = vxsat_q;
      12'h00A: csr_rdata[1:0]     = vxrm_q;
      12'h00F: csr_rdata[2:0]     = {vxrm_q, vxsat_q};
      12'hC20: begin
        csr_rdata = vl_q;
        csr_ro    = 1'b1;
      end
      12'hC21: begin
        csr_rdata[XLEN-1] = vill_q;
        csr_rdata[7:0]    = {vma_q, vta_q, vsew_q, vlmul_q};
        csr_ro            = 1'b1;
      end
      12'hC22: begin
        csr_rdata = XLEN'(VLEN / 8);
        csr_ro    = 1'b1;
      end
      default: csr_unmapped = 1'b1;
    endcase
  end

  assign csr_illegal = csr_valid & (csr_unmapped | (csr_ro & csr_wr_intent));
  assign csr_we      = csr_valid & csr_ready & csr_wr_intent & ~csr_illegal;

  always_comb begin
    case (csr_op)
      2'd1:    csr_new = csr_rdata | csr_wdata;
      2'd2:    csr_new = csr_rdata & ~csr_wdata;
      default: csr_new = csr_wdata;
    endcase
  end

  logic unused_bits;
  assign unused_bits = ^{cfg_vtype[XLEN-1], csr_new[XLEN-1:VLW]};

  assign cfg_ready   = (state_q == IDLE);
  assign csr_ready   = (state_q == IDLE);
  assign issue_ready = (state_q == IDLE) & ~cfg_valid & (cnt_q < CW'(MAX_INFLIGHT));

  always_comb begin
    vstart_d = vstart_q;
    if (state_q == COMMIT)                 vstart_d = '0;
    else if (vstart_clr)                   vstart_d = '0;
    else if (csr_we && csr_addr == 12'h008) vstart_d = csr_new[VLW-1:0];

    vxrm_d  = vxrm_q;
    vxsat_d = vxsat_q;
    if (csr_we && csr_addr == 12'h009) vxsat_d = csr_new[0];
    if (csr_we && csr_addr == 12'h00A) vxrm_d  = csr_new[1:0];
    if (csr_we && csr_addr == 12'h00F) begin
      vxrm_d  = csr_new[2:1];
      vxsat_d = csr_new[0];
    end
    vxsat_d = vxsat_d | vxsat_set;

    cnt_d = cnt_q;
    if (issue_valid && issue_ready && retire_valid) cnt_d = cnt_q;
    else if (issue_valid && issue_ready)            cnt_d = cnt_q + CW'(1);
    else if (retire_valid && cnt_q != '0)           cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= IDLE;
      req_avl_q   <= '0;
      req_vtype_q <= '0;
      req_rs1z_q  <= 1'b0;
      req_rdz_q   <= 1'b0;
      vill_q      <= 1'b1;
      vma_q       <= 1'b0;
      vta_q       <= 1'b0;
      vsew_q      <= '0;
      vlmul_q     <= '0;
      vl_q        <= '0;
      vstart_q    <= '0;
      vxrm_q      <= '0;
      vxsat_q     <= 1'b0;
      cnt_q       <= '0;
      cfg_done_q  <= 1'b0;
      cfg_vl_q    <= '0;
    end else begin
      vstart_q   <= vstart_d;
      vxrm_q     <= vxrm_d;
      vxsat_q    <= vxsat_d;
      cnt_q      <= cnt_d;
      cfg_done_q <= 1'b0;
      case (state_q)
        IDLE: if (cfg_valid) begin
          req_avl_q   <= cfg_avl;
          req_vtype_q <= cfg_vtype[XLEN-2:0];
          req_rs1z_q  <= cfg_rs1_zero;
          req_rdz_q   <= cfg_rd_zero;
          state_q     <= DRAIN;
        end
        DRAIN: if (cnt_q == '0) state_q <= COMMIT;
        COMMIT: begin
          vill_q     <= new_vill;
          vma_q      <= ~new_vill & req_vtype_q[7];
          vta_q      <= ~new_vill & req_vtype_q[6];
          vsew_q     <= new_vill ? 3'd0 : req_vsew;
          vlmul_q    <= new_vill ? 3'd0 : req_vlmul;
          vl_q       <= new_vl;
          cfg_vl_q   <= new_vl;
          cfg_done_q <= 1'b1;
          state_q    <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign cfg_done = cfg_done_q;
  assign cfg_vl   = cfg_vl_q;
  assign sew      = 7'd8 << vsew_q;
  assign vlmul    = vlmul_q;
  assign vlmax    = vlmax_cur;
  assign vl       = vl_q;
  assign vstart   = vstart_q;
  assign vta      = vta_q;
  assign vma      = vma_q;
  assign vill     = vill_q;
  assign vxrm     = vxrm_q;
  assign vxsat    = vxsat_q;

endmodule

// File: tb/tb_vec_csr_unit.sv
// Bench for vec_csr_unit: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model.
module tb_vec_csr_unit;
  localparam int XLEN = 32, VLEN = 512, ELEN = 64, MAXI = 4;

  logic        clk = 1'b0, n_rst = 1'b1;
  logic        cfg_valid, cfg_ready, cfg_rs1_zero, cfg_rd_zero, cfg_done;
  logic [31:0] cfg_avl, cfg_vtype, cfg_vl;
  logic        issue_valid, issue_ready, retire_valid;
  logic        csr_valid, csr_ready, csr_wr_intent, csr_illegal;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata, csr_rdata;
  logic        vstart_clr, vxsat_set;
  logic [6:0]  sew;
  logic [2:0]  vlmul;
  logic [9:0]  vlmax;
  logic [31:0] vl;
  logic [8:0]  vstart;
  logic        vta, vma, vill, vxsat;
  logic [1:0]  vxrm;

  vec_csr_unit #(.XLEN(XLEN), .VLEN(VLEN), .ELEN(ELEN), .MAX_INFLIGHT(MAXI)) dut (
    .clk(clk), .n_rst(n_rst),
    .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_avl(cfg_avl), .cfg_vtype(cfg_vtype),
    .cfg_rs1_zero(cfg_rs1_zero), .cfg_rd_zero(cfg_rd_zero), .cfg_done(cfg_done), .cfg_vl(cfg_vl),
    .issue_valid(issue_valid), .issue_ready(issue_ready), .retire_valid(retire_valid),
    .csr_valid(csr_valid), .csr_ready(csr_ready), .csr_op(csr_op), .csr_wr_intent(csr_wr_intent),
    .csr_addr(csr_addr), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata), .csr_illegal(csr_illegal),
    .vstart_clr(vstart_clr), .vxsat_set(vxsat_set),
    .sew(sew), .vlmul(vlmul), .vlmax(vlmax), .vl(vl), .vstart(vstart),
    .vta(vta), .vma(vma), .vill(vill), .vxrm(vxrm), .vxsat(vxsat)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit              m_vill, m_vma, m_vta, m_vxsat, m_done;
  int              m_vsew, m_vlmul, m_vstart, m_vxrm, m_cnt, m_stage;
  longint unsigned m_vl, m_cfg_vl;
  logic [31:0]     r_avl, r_vtype;
  bit              r_rs1z, r_rdz;

  function automatic int model_vlmax(input int vs, input int lm);
    int sb, num, den;
    sb = 8 << vs; num = 1; den = 1;
    if (lm < 4) num = 1 << lm; else den = 1 << (8 - lm);
    return (VLEN * num) / (sb * den);
  endfunction

  function automatic bit model_legal(input logic [31:0] vt);
    int vs, lm, num, den;
    vs = int'(vt[5:3]); lm = int'(vt[2:0]);
    if (vs > 3 || lm == 4 || vt[30:8] != 0) return 0;
    num = 1; den = 1;
    if (lm < 4) num = 1 << lm; else den = 1 << (8 - lm);
    return ((8 << vs) * den <= ELEN * num);
  endfunction

  task automatic model_reset();
    m_vill = 1; m_vma = 0; m_vta = 0; m_vsew = 0; m_vlmul = 0; m_vl = 0;
    m_vstart = 0; m_vxrm = 0; m_vxsat = 0; m_cnt = 0; m_stage = 0;
    m_done = 0; m_cfg_vl = 0;
  endtask

  task automatic model_csr(input logic [11:0] a, output longint unsigned d, output bit unm, output bit ro);
    d = 0; unm = 0; ro = 0;
    case (a)
      12'h008: d = m_vstart;
      12'h009: d = m_vxsat;
      12'h00A: d = m_vxrm;
      12'h00F: d = m_vxrm * 2 + m_vxsat;
      12'hC20: begin d = m_vl; ro = 1; end
      12'hC21: begin
        d = (longint'(m_vill) << 31) + m_vma * 128 + m_vta * 64 + m_vsew * 8 + m_vlmul;
        ro = 1;
      end
      12'hC22: begin d = VLEN / 8; ro = 1; end
      default: unm = 1;
    endcase
  endtask

  task automatic model_step();
    longint unsigned rd, nv, avl, nvm;
    bit unm, ro, ill, we, idle, irdy, nvill;
    int n_vstart, n_vxrm, n_cnt;
    bit n_vxsat;
    idle = (m_stage == 0);
    irdy = idle && !cfg_valid && m_cnt < MAXI;
    model_csr(csr_addr, rd, unm, ro);
    ill = unm || (ro && csr_wr_intent);
    we  = csr_valid && idle && csr_wr_intent && !ill;
    case (csr_op)
      2'd1:    nv = rd | csr_wdata;
      2'd2:    nv = rd & ~longint'(csr_wdata);
      default: nv = csr_wdata;
    endcase
    n_vstart = m_vstart;
    if (m_stage == 2 || vstart_clr) n_vstart = 0;
    else if (we && csr_addr == 12'h008) n_vstart = int'(nv % VLEN);
    n_vxrm = m_vxrm; n_vxsat = m_vxsat;
    if (we && csr_addr == 12'h009) n_vxsat = nv[0];
    if (we && csr_addr == 12'h00A) n_vxrm = int'(nv % 4);
    if (we && csr_addr == 12'h00F) begin n_vxrm = int'((nv / 2) % 4); n_vxsat = nv[0]; end
    n_vxsat = n_vxsat | vxsat_set;
    n_cnt = m_cnt;
    if (irdy && issue_valid && !retire_valid) n_cnt = m_cnt + 1;
    else if (retire_valid && !(irdy && issue_valid) && m_cnt > 0) n_cnt = m_cnt - 1;

    m_done = 0;
    if (m_stage == 2) begin
      nvill = !model_legal(r_vtype);
      avl = 0; nvm = 0;
      if (!nvill) begin
        nvm = model_vlmax(int'(r_vtype[5:3]), int'(r_vtype[2:0]));
        if (!r_rs1z) avl = r_avl;
        else if (!r_rdz) avl = nvm;
        else begin
          avl = m_vl;
          if (nvm != model_vlmax(m_vsew, m_vlmul)) nvill = 1;
        end
      end
      m_vill = nvill;
      if (nvill) begin
        m_vma = 0; m_vta = 0; m_vsew = 0; m_vlmul = 0; m_vl = 0;
      end else begin
        m_vma = r_vtype[7]; m_vta = r_vtype[6];
        m_vsew = int'(r_vtype[5:3]); m_vlmul = int'(r_vtype[2:0]);
        m_vl = (avl < nvm) ? avl : nvm;
      end
      m_cfg_vl = m_vl; m_done = 1; m_stage = 0;
    end else if (m_stage == 1) begin
      if (m_cnt == 0) m_stage = 2;
    end else if (cfg_valid) begin
      r_avl = cfg_avl; r_vtype = cfg_vtype; r_rs1z = cfg_rs1_zero; r_rdz = cfg_rd_zero;
      m_stage = 1;
    end
    m_vstart = n_vstart; m_vxrm = n_vxrm; m_vxsat = n_vxsat; m_cnt = n_cnt;
  endtask

  // One compare process: outputs checked mid-cycle, then model advanced.
  always @(negedge clk) begin
    longint unsigned rd;
    bit unm, ro;
    if (!n_rst) model_reset();
    chk("cfg_ready", cfg_ready, m_stage == 0);
    chk("csr_ready", csr_ready, m_stage == 0);
    chk("issue_ready", issue_ready, m_stage == 0 && !cfg_valid && m_cnt < MAXI);
    chk("cfg_done", cfg_done, m_done);
    chk("cfg_vl", cfg_vl, m_cfg_vl);
    chk("sew", sew, 8 << m_vsew);
    chk("vlmul", vlmul, m_vlmul);
    chk("vlmax", vlmax, model_vlmax(m_vsew, m_vlmul));
    chk("vl", vl, m_vl);
    chk("vstart", vstart, m_vstart);
    chk("vta", vta, m_vta);
    chk("vma", vma, m_vma);
    chk("vill", vill, m_vill);
    chk("vxrm", vxrm, m_vxrm);
    chk("vxsat", vxsat, m_vxsat);
    if (csr_valid) begin
      model_csr(csr_addr, rd, unm, ro);
      chk("csr_rdata", csr_rdata, rd);
      chk("csr_illegal", csr_illegal, unm || (ro && csr_wr_intent));
    end
    if (n_rst) model_step();
  end

  // ---------------- stimulus ----------------
  task automatic clr();
    cfg_valid = 0; cfg_avl = 0; cfg_vtype = 0; cfg_rs1_zero = 0; cfg_rd_zero = 0;
    issue_valid = 0; retire_valid = 0;
    csr_valid = 0; csr_op = 0; csr_wr_intent = 0; csr_addr = 0; csr_wdata = 0;
    vstart_clr = 0; vxsat_set = 0;
  endtask

  task automatic tick();
    @(posedge clk); #1; clr();
  endtask

  task automatic cfg_req(input logic [31:0] avl, input logic [31:0] vt, input bit rs1z, input bit rdz);
    cfg_valid = 1; cfg_avl = avl; cfg_vtype = vt; cfg_rs1_zero = rs1z; cfg_rd_zero = rdz;
    tick();
  endtask

  task automatic wait_done(output int n);
    n = 0;
    while (!cfg_done && n < 40) begin tick(); n++; end
    if (!cfg_done) chk("cfg_done_timeout", cfg_done, 1);
  endtask

  task automatic csr_acc(input logic [11:0] a, input logic [1:0] op, input bit wi, input logic [31:0] wd);
    csr_valid = 1; csr_addr = a; csr_op = op; csr_wr_intent = wi; csr_wdata = wd;
  endtask

  logic [11:0] addrs [10] = '{12'h008, 12'h009, 12'h00A, 12'h00F, 12'hC20,
                              12'hC21, 12'hC22, 12'h000, 12'hC23, 12'h7FF};

  initial begin
    int n;
    int retired;
    logic [31:0] vt;
    clr();
    #1 n_rst = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_vill", vill, 1);
    chk("rst_vl", vl, 0);
    chk("rst_sew", sew, 8);
    chk("rst_vlmax", vlmax, 64);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_cfg_done", cfg_done, 0);
    n_rst = 1;
    tick();

    cfg_req(100, 32'h010, 0, 0);
    wait_done(n);
    chk("lat_sew32", n, 2);
    chk("vl_sew32", vl, 16);
    chk("cfg_vl_sew32", cfg_vl, 16);
    chk("sew_sew32", sew, 32);
    chk("vill_sew32", vill, 0);
    tick();
    chk("done_pulse", cfg_done, 0);

    cfg_req(100, 32'h001, 0, 0);
    wait_done(n);
    chk("vl_lmul2", vl, 100);
    chk("vlmax_lmul2", vlmax, 128);

    cfg_req(100, 32'h01F, 0, 0);
    wait_done(n);
    chk("vill_sew64_mf2", vill, 1);
    chk("vl_sew64_mf2", vl, 0);
    csr_acc(12'hC21, 0, 0, 0);
    #1 chk("vtype_rd_vill", csr_rdata, 32'h8000_0000);
    tick();

    repeat (3) begin issue_valid = 1; tick(); end
    cfg_req(100, 32'h010, 0, 0);
    retired = 0;
    for (n = 0; n < 40 && !cfg_done; n++) begin
      retire_valid = (n % 2 == 0) && retired < 3;
      if (retire_valid) retired++;
      issue_valid = 1;
      chk("drain_issue_ready", issue_ready, 0);
      chk("drain_cfg_done", cfg_done, 0);
      tick();
    end
    // Last retire at the 5th cycle; count hits zero next cycle, done two after.
    chk("drain_latency", n, 7);
    chk("drain_vl", vl, 16);

    csr_acc(12'h00A, 0, 1, 2); tick();
    csr_acc(12'h00F, 0, 0, 0);
    #1 chk("vcsr_rd", csr_rdata, 4);
    tick();
    csr_acc(12'hC20, 1, 1, 5);
    #1 chk("vl_ro_illegal", csr_illegal, 1);
    tick();
    chk("vl_ro_unchanged", vl, 16);
    csr_acc(12'h009, 0, 1, 0); vxsat_set = 1; tick();
    chk("vxsat_set_wins", vxsat, 1);
    csr_acc(12'h008, 0, 1, 32'h3FF); tick();
    chk("vstart_mask", vstart, 9'h1FF);

    cfg_req(0, 32'h050, 1, 1);
    wait_done(n);
    chk("keep_vl", vl, 16);
    chk("keep_vta", vta, 1);
    chk("keep_vill", vill, 0);
    chk("commit_vstart_clr", vstart, 0);

    cfg_req(0, 32'h011, 1, 1);
    wait_done(n);
    chk("keep_vlmax_change_vill", vill, 1);
    chk("keep_vlmax_change_vl", vl, 0);

    cfg_req(100, 32'h010, 0, 0);
    wait_done(n);
    repeat (2) begin issue_valid = 1; tick(); end
    cfg_req(7, 32'h008, 0, 0);
    n_rst = 0;
    #1;
    chk("rst_drain_ready", cfg_ready, 1);
    chk("rst_drain_vill", vill, 1);
    tick();
    n_rst = 1;
    repeat (4) begin tick(); chk("rst_drain_no_done", cfg_done, 0); end

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 499) == 0) begin n_rst = 0; tick(); tick(); n_rst = 1; end
      vt = $urandom & 32'h8000_00FF;
      vt[5] = ($urandom_range(0, 5) == 0);
      if ($urandom_range(0, 15) == 0) vt[8 + $urandom_range(0, 22)] = 1'b1;
      cfg_valid     = ($urandom_range(0, 9) == 0);
      cfg_avl       = ($urandom_range(0, 3) == 0) ? $urandom : $urandom_range(0, 600);
      cfg_vtype     = vt;
      cfg_rs1_zero  = ($urandom_range(0, 3) == 0);
      cfg_rd_zero   = ($urandom_range(0, 1) == 0);
      issue_valid   = ($urandom_range(0, 2) == 0);
      retire_valid  = ($urandom_range(0, 2) == 0);
      csr_valid     = ($urandom_range(0, 3) == 0);
      csr_op        = 2'($urandom_range(0, 2));
      csr_addr      = addrs[$urandom_range(0, 9)];
      csr_wr_intent = ($urandom_range(0, 1) == 0);
      csr_wdata     = $urandom;
      vstart_clr    = ($urandom_range(0, 15) == 0);
      vxsat_set     = ($urandom_range(0, 15) == 0);
      tick();
    end
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

endmodule
